// File: rtl/seg_pipe_adder.sv
// Pipelined carry-select adder/subtractor: one SEG-bit segment per stage, LSB first.
// Each stage forms both carry-in sums of its segment and picks one with the carry registered by the stage before.
module seg_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_zero
);
    localparam int STAGES = WIDTH / SEG;

    if (WIDTH % SEG != 0) begin : g_bad_params
        $error("seg_pipe_adder: WIDTH must be a multiple of SEG");
    end

    // Handshake: a request transfers on a rising edge where in_valid && in_ready,
    // a result transfers where out_valid && out_ready; the whole pipe advances
    // together only when the output slot is empty or being consumed.
    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Subtraction is A + ~B + ~borrow.
    logic [WIDTH-1:0] b_prep;
    logic             c0;
    assign b_prep = in_sub ? ~in_b : in_b;
    assign c0     = in_cin ^ in_sub;

    logic [STAGES-1:0]            v_in, c_in, c_next, v_q, c_q;
    logic [STAGES-1:0][WIDTH-1:0] a_in, b_in, s_in, s_new;
    logic [STAGES-1:0][WIDTH-1:0] a_q, b_q, sum_q;
    logic [STAGES-1:0][SEG:0]     s0, s1, sel;
    logic                         msb_cin, msb_cin_q;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign v_in[k] = in_valid;
            assign a_in[k] = in_a;
            assign b_in[k] = b_prep;
            assign c_in[k] = c0;
            assign s_in[k] = '0;
        end else begin : g_link
            assign v_in[k] = v_q[k-1];
            assign a_in[k] = a_q[k-1];
            assign b_in[k] = b_q[k-1];
            assign c_in[k] = c_q[k-1];
            assign s_in[k] = sum_q[k-1];
        end

        assign s0[k]     = {1'b0, a_in[k][k*SEG +: SEG]} + {1'b0, b_in[k][k*SEG +: SEG]};
        assign s1[k]     = {1'b0, a_in[k][k*SEG +: SEG]} + {1'b0, b_in[k][k*SEG +: SEG]}
                           + (SEG+1)'(1);
        assign sel[k]    = c_in[k] ? s1[k] : s0[k];
        assign c_next[k] = sel[k][SEG];
        // Completed low bits ride along; this stage fills in its own segment.
        assign s_new[k]  = s_in[k] | (WIDTH'(sel[k][SEG-1:0]) << (k*SEG));
    end

    // Carry into the MSB recovered from its sum bit: s = a ^ b ^ cin.
    assign msb_cin = sel[STAGES-1][SEG-1] ^ a_in[STAGES-1][WIDTH-1] ^ b_in[STAGES-1][WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q       <= '0;
            c_q       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            msb_cin_q <= 1'b0;
        end else if (en) begin
            v_q       <= v_in;
            c_q       <= c_next;
            a_q       <= a_in;
            b_q       <= b_in;
            sum_q     <= s_new;
            msb_cin_q <= msb_cin;
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign out_sum   = sum_q[STAGES-1];
    assign out_carry = c_q[STAGES-1];
    assign out_ovf   = msb_cin_q ^ c_q[STAGES-1];
    assign out_zero  = v_q[STAGES-1] && (sum_q[STAGES-1] == '0);

    // Operand bits already consumed by earlier segments are carried but never read.
    logic unused_pipe;
    assign unused_pipe = ^{a_in, b_in, a_q[STAGES-1], b_q[STAGES-1]};

endmodule

// File: tb/tb_seg_pipe_adder.sv
// Self-checking bench for seg_pipe_adder (WIDTH=16, SEG=4): fixed vectors, handshake
// sequences and random traffic scored against an arithmetic reference model.
module tb_seg_pipe_adder;
    localparam int WIDTH = 16;
    localparam int SEG   = 4;
    localparam int LAT   = WIDTH / SEG;
    localparam int EW    = WIDTH + 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, in_ready, in_sub, in_cin;
    logic [WIDTH-1:0] in_a, in_b;
    logic             out_valid, out_ready, out_carry, out_ovf, out_zero;
    logic [WIDTH-1:0] out_sum;

    // clock / reset
    always #5 clk = ~clk;

    seg_pipe_adder #(.WIDTH(WIDTH), .SEG(SEG)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_carry(out_carry), .out_ovf(out_ovf), .out_zero(out_zero)
    );

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             sub;
        logic             cin;
        logic [WIDTH-1:0] sum;
        logic             carry;
        logic             ovf;
        logic             zero;
    } vec_t;

    int n_checks   = 0;
    int n_pass     = 0;
    int out_count  = 0;
    logic [EW-1:0] exp_q[$];
    logic          prev_stalled = 1'b0;
    logic [EW:0]   prev_out;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model: {zero, ovf, carry, sum} from plain integer arithmetic.
    function automatic logic [EW-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                            input logic sub, input logic cin);
        int ua, ub, ci, sa, sb, r, sr;
        logic carry, ovf;
        logic [WIDTH-1:0] sum;
        ua = int'(a);
        ub = int'(b);
        ci = cin ? 1 : 0;
        sa = $signed(a);
        sb = $signed(b);
        if (!sub) begin
            r     = ua + ub + ci;
            sr    = sa + sb + ci;
            carry = (r > 65535);
        end else begin
            r     = ua - ub - ci;
            sr    = sa - sb - ci;
            carry = (r >= 0);
        end
        sum = r[WIDTH-1:0];
        ovf = (sr > 32767) || (sr < -32768);
        return {(sum == 0), ovf, carry, sum};
    endfunction

    function automatic logic [WIDTH-1:0] rand_op();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            default: return WIDTH'($urandom);
        endcase
    endfunction

    // scoreboard side: runs once per cycle, after inputs for that cycle are set
    task automatic monitor();
        logic [EW-1:0] e;
        if (prev_stalled)
            check("stall_hold", 32'({out_valid, out_zero, out_ovf, out_carry, out_sum}), 32'(prev_out));
        check("in_ready_rule", 32'(in_ready), 32'(!(out_valid && !out_ready)));
        if (out_valid && out_ready) begin
            out_count++;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_output: got sum 0x%0h, expected no output", out_sum);
            end else begin
                e = exp_q.pop_front();
                check("result", 32'({out_zero, out_ovf, out_carry, out_sum}), 32'(e));
            end
        end
    endtask

    // driver: one cycle, inputs set on the falling edge
    task automatic tick(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic sub, input logic cin, input logic ordy,
                        input logic [EW-1:0] exp, output logic acc);
        @(negedge clk);
        out_ready = ordy;
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_sub    = sub;
        in_cin    = cin;
        #1;
        monitor();
        acc = v && in_ready;
        if (acc) exp_q.push_back(exp);
        prev_stalled = out_valid && !out_ready;
        prev_out     = {out_valid, out_zero, out_ovf, out_carry, out_sum};
    endtask

    task automatic idle(input logic ordy);
        logic acc;
        tick(1'b0, '0, '0, 1'b0, 1'b0, ordy, '0, acc);
    endtask

    task automatic drain(input logic random_ready);
        int guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            idle(random_ready ? 1'($urandom_range(0, 1)) : 1'b1);
            guard++;
        end
        check("drain_done", 32'(exp_q.size()), 32'd0);
        idle(1'b1);
    endtask

    vec_t tbl[10];

    initial begin
        logic acc;
        logic [WIDTH-1:0] a, b;
        logic s, c, v;
        logic acc_h[32];
        int cnt0, guard;

        tbl[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{16'h0009, 16'h0003, 1'b1, 1'b1, 16'h0005, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
        tbl[8] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        tbl[9] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_sub = 1'b0; in_cin = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready",  32'(in_ready),  32'd1);
        check("reset_out_sum",   32'(out_sum),   32'd0);
        check("reset_out_carry", 32'(out_carry), 32'd0);
        check("reset_out_ovf",   32'(out_ovf),   32'd0);
        check("reset_out_zero",  32'(out_zero),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // fixed vectors, one at a time, with latency check
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].cin, 1'b1,
                 {tbl[i].zero, tbl[i].ovf, tbl[i].carry, tbl[i].sum}, acc);
            check("tbl_accept", 32'(acc), 32'd1);
            for (int d = 1; d <= LAT; d++) begin
                idle(1'b1);
                check("tbl_latency", 32'(out_valid), 32'(d == LAT));
            end
        end
        drain(1'b0);

        // back-to-back requests under random backpressure
        cnt0 = out_count;
        for (int i = 0; i < 8; i++) begin
            a = WIDTH'(i);
            b = WIDTH'(16'h1000 * i);
            guard = 0;
            do begin
                tick(1'b1, a, b, 1'b0, 1'b0, 1'($urandom_range(0, 1)), model(a, b, 1'b0, 1'b0), acc);
                guard++;
            end while (!acc && guard < 50);
            check("bp_accept", 32'(acc), 32'd1);
        end
        drain(1'b1);
        check("bp_result_count", 32'(out_count - cnt0), 32'd8);

        // bubbles: valid on alternate cycles, out_valid mirrors that pattern LAT cycles later
        for (int i = 0; i < 20; i++) begin
            v = (i < 12) && (i % 2 == 0);
            a = rand_op();
            b = rand_op();
            s = 1'($urandom_range(0, 1));
            c = 1'($urandom_range(0, 1));
            tick(v, a, b, s, c, 1'b1, model(a, b, s, c), acc);
            acc_h[i] = acc;
            check("bubble_spacing", 32'(out_valid), 32'((i >= LAT) ? acc_h[i-LAT] : 1'b0));
        end
        drain(1'b0);

        // random traffic
        for (int i = 0; i < 150; i++) begin
            v = ($urandom_range(0, 3) != 0);
            a = rand_op();
            b = rand_op();
            s = 1'($urandom_range(0, 1));
            c = 1'($urandom_range(0, 1));
            tick(v, a, b, s, c, 1'($urandom_range(0, 3) != 0), model(a, b, s, c), acc);
        end
        drain(1'b1);

        // reset with requests in flight
        for (int i = 0; i < LAT; i++) begin
            a = rand_op();
            b = rand_op();
            tick(1'b1, a, b, 1'b0, 1'b0, 1'b1, model(a, b, 1'b0, 1'b0), acc);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("rst_pre_out_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum",   32'(out_sum),   32'd0);
        check("rst_out_zero",  32'(out_zero),  32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        exp_q.delete();
        prev_stalled = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cnt0 = out_count;
        tick(1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b1, {1'b0, 1'b0, 1'b0, 16'h2345}, acc);
        check("rst_post_accept", 32'(acc), 32'd1);
        repeat (LAT + 6) idle(1'b1);
        check("rst_single_output", 32'(out_count - cnt0), 32'd1);
        check("rst_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
